// File: rtl/i2c_xfer_sequencer_pkg.sv
// ==== i2c_xfer_sequencer_pkg : byte-controller command codes, error codes, sequencer states (rev 1.0) ====
`default_nettype none

package i2c_xfer_sequencer_pkg;

  localparam logic [3:0] CMD_IDLE    = 4'd0;
  localparam logic [3:0] CMD_START   = 4'd1;
  localparam logic [3:0] CMD_WRITE   = 4'd2;
  localparam logic [3:0] CMD_READ    = 4'd3;
  localparam logic [3:0] CMD_RD_ACK  = 4'd4;
  localparam logic [3:0] CMD_WR_ACK  = 4'd5;
  localparam logic [3:0] CMD_WR_NAK  = 4'd6;
  localparam logic [3:0] CMD_RESTART = 4'd7;
  localparam logic [3:0] CMD_STOP    = 4'd8;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_AL      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_DEVW      = 4'd2,
    ST_DEVW_ACK  = 4'd3,
    ST_REG       = 4'd4,
    ST_REG_ACK   = 4'd5,
    ST_WDATA     = 4'd6,
    ST_WDATA_ACK = 4'd7,
    ST_RESTART   = 4'd8,
    ST_DEVR      = 4'd9,
    ST_DEVR_ACK  = 4'd10,
    ST_RDATA     = 4'd11,
    ST_RDATA_ACK = 4'd12,
    ST_STOP      = 4'd13,
    ST_DONE      = 4'd14
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_watchdog.sv
// ==== i2c_cmd_watchdog : counts cycles since the last command strobe, flags expiry (rev 1.0) ====
`default_nettype none

module i2c_cmd_watchdog #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int         CW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // The strobe cycle itself is the first elapsed cycle, hence the load of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(1);
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/i2c_xfer_sequencer.sv
// ==== i2c_xfer_sequencer : register read/write transaction sequencer for the I2C byte controller (rev 1.0) ====
`default_nettype none

module i2c_xfer_sequencer
  import i2c_xfer_sequencer_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             i_sysclk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic             i_rnw,
  input  logic [6:0]       i_dev_addr,
  input  logic [7:0]       i_reg_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_err,
  input  logic [7:0]       i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  output logic             o_cmd_trig,
  output logic [3:0]       o_cmd,
  output logic [7:0]       o_data,
  input  logic             i_cmd_ack,
  input  logic             i_i2c_ack,
  input  logic             i_i2c_al,
  input  logic [7:0]       i_data
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  seq_state_e       state, state_n;
  logic             waiting, waiting_n;
  logic             rnw;
  logic [6:0]       dev_addr;
  logic [7:0]       reg_addr;
  logic [7:0]       wbyte;
  logic [LEN_W-1:0] count, count_n;
  logic [1:0]       err, err_n;
  logic             accept, rd_capture, wd_clear, wd_expire;

  i2c_cmd_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (i_sysclk),
    .rst    (i_reset),
    .clear  (wd_clear),
    .enable (waiting),
    .expire (wd_expire)
  );

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      waiting <= 1'b0;
    end else begin
      state   <= state_n;
      waiting <= waiting_n;
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      rnw        <= 1'b0;
      dev_addr   <= '0;
      reg_addr   <= '0;
      wbyte      <= '0;
      count      <= '0;
      err        <= ERR_OK;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      if (accept) begin
        rnw      <= i_rnw;
        dev_addr <= i_dev_addr;
        reg_addr <= i_reg_addr;
      end
      if (o_wr_ready) wbyte <= i_wr_data;
      count      <= count_n;
      err        <= err_n;
      o_rd_valid <= rd_capture;
      if (rd_capture) o_rd_data <= i_data;
    end
  end

  assign o_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done = (state == ST_DONE);
  assign o_err  = (state == ST_DONE) ? err : ERR_OK;

  always_comb begin
    state_n    = state;
    waiting_n  = waiting;
    count_n    = count;
    err_n      = err;
    accept     = 1'b0;
    rd_capture = 1'b0;
    wd_clear   = 1'b0;
    o_cmd_trig = 1'b0;
    o_wr_ready = 1'b0;
    o_cmd      = CMD_IDLE;
    o_data     = 8'hFF;

    // Command and operand are a function of state, so they hold through WAIT.
    case (state)
      ST_START:     o_cmd = CMD_START;
      ST_DEVW:      begin o_cmd = CMD_WRITE; o_data = {dev_addr, 1'b0}; end
      ST_REG:       begin o_cmd = CMD_WRITE; o_data = reg_addr; end
      ST_WDATA:     begin o_cmd = CMD_WRITE; o_data = waiting ? wbyte : i_wr_data; end
      ST_DEVW_ACK, ST_REG_ACK, ST_WDATA_ACK, ST_DEVR_ACK:
                    o_cmd = CMD_RD_ACK;
      ST_RESTART:   o_cmd = CMD_RESTART;
      ST_DEVR:      begin o_cmd = CMD_WRITE; o_data = {dev_addr, 1'b1}; end
      ST_RDATA:     o_cmd = CMD_READ;
      ST_RDATA_ACK: o_cmd = (count == ONE) ? CMD_WR_NAK : CMD_WR_ACK;
      ST_STOP:      o_cmd = CMD_STOP;
      default:      ;
    endcase

    if (state == ST_IDLE) begin
      if (i_req) begin
        accept  = 1'b1;
        state_n = ST_START;
        count_n = (i_len == '0) ? ONE : i_len;
        err_n   = ERR_OK;
      end
    end else if (state == ST_DONE) begin
      state_n = ST_IDLE;
    end else if (i_i2c_al) begin
      state_n   = ST_DONE;
      waiting_n = 1'b0;
      err_n     = ERR_AL;
    end else if (!waiting) begin
      if ((state != ST_WDATA) || i_wr_valid) begin
        o_cmd_trig = 1'b1;
        o_wr_ready = (state == ST_WDATA);
        wd_clear   = 1'b1;
        waiting_n  = 1'b1;
      end
    end else if (i_cmd_ack) begin
      waiting_n = 1'b0;
      if ((o_cmd == CMD_RD_ACK) && i_i2c_ack) begin
        err_n   = ERR_NACK;
        state_n = ST_STOP;
      end else begin
        case (state)
          ST_START:     state_n = ST_DEVW;
          ST_DEVW:      state_n = ST_DEVW_ACK;
          ST_DEVW_ACK:  state_n = ST_REG;
          ST_REG:       state_n = ST_REG_ACK;
          ST_REG_ACK:   state_n = rnw ? ST_RESTART : ST_WDATA;
          ST_WDATA:     state_n = ST_WDATA_ACK;
          ST_WDATA_ACK: begin
            if (count == ONE) state_n = ST_STOP;
            else begin count_n = count - ONE; state_n = ST_WDATA; end
          end
          ST_RESTART:   state_n = ST_DEVR;
          ST_DEVR:      state_n = ST_DEVR_ACK;
          ST_DEVR_ACK:  state_n = ST_RDATA;
          ST_RDATA:     begin rd_capture = 1'b1; state_n = ST_RDATA_ACK; end
          ST_RDATA_ACK: begin
            if (count == ONE) state_n = ST_STOP;
            else begin count_n = count - ONE; state_n = ST_RDATA; end
          end
          ST_STOP:      state_n = ST_DONE;
          default:      state_n = ST_IDLE;
        endcase
      end
    end else if (wd_expire) begin
      state_n   = ST_DONE;
      waiting_n = 1'b0;
      err_n     = ERR_TIMEOUT;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_xfer_sequencer.sv
// ==== tb_i2c_xfer_sequencer : byte-controller responder, transaction reference model, scenario tasks (rev 1.0) ====
`default_nettype none

module tb_i2c_xfer_sequencer;

  localparam int LEN_W = 4;
  localparam int TO    = 16;
  localparam logic [3:0] C_IDLE = 4'd0, C_START = 4'd1, C_WRITE = 4'd2, C_READ = 4'd3,
                         C_RD_ACK = 4'd4, C_WR_ACK = 4'd5, C_WR_NAK = 4'd6,
                         C_RESTART = 4'd7, C_STOP = 4'd8;

  logic clk = 1'b0;
  logic i_reset = 1'b1, i_req = 1'b0, i_rnw = 1'b0;
  logic [6:0] i_dev_addr = '0;
  logic [7:0] i_reg_addr = '0;
  logic [LEN_W-1:0] i_len = '0;
  logic o_busy, o_done, o_wr_ready, o_rd_valid, o_cmd_trig;
  logic [1:0] o_err;
  logic [7:0] i_wr_data, o_rd_data, o_data, i_data;
  logic i_wr_valid, i_cmd_ack, i_i2c_ack, i_i2c_al;
  logic [3:0] o_cmd;

  i2c_xfer_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
    .i_sysclk(clk), .i_reset(i_reset), .i_req(i_req), .i_rnw(i_rnw),
    .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_cmd_trig(o_cmd_trig), .o_cmd(o_cmd), .o_data(o_data),
    .i_cmd_ack(i_cmd_ack), .i_i2c_ack(i_i2c_ack), .i_i2c_al(i_i2c_al), .i_data(i_data)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // Observations collected by the responder.
  logic [11:0] cmd_log[$];
  logic [7:0]  rd_log[$], wq[$], rq[$];
  int cyc = 0, wr_pulses = 0, done_count = 0, done_cyc = 0, last_trig_cyc = 0, al_cyc = 0;
  int unstable = 0, rdack_seen = 0, wait_left = 0;
  int nack_at = -1, al_at = -1, noack_at = -1;
  logic [1:0] done_err = '0;
  logic busy_at_done = 1'b0, req_busy = 1'b0;
  bit pending = 0, wr_taken = 0;
  logic [3:0] pend_cmd = '0;
  logic [7:0] pend_data = '0;

  // Reference model results.
  logic [11:0] exp_cmd[$];
  logic [7:0]  exp_rd[$], wbytes[$], rbytes[$];
  int exp_wr = 0;
  logic [1:0] exp_err = '0;

  // Byte-controller responder and output monitor.
  initial begin
    i_cmd_ack = 0; i_i2c_ack = 0; i_i2c_al = 0; i_data = 0; i_wr_valid = 0; i_wr_data = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      i_cmd_ack = 0; i_i2c_al = 0;
      if (wr_taken) begin
        if (wq.size() > 0) void'(wq.pop_front());
        wr_taken = 0;
      end
      i_wr_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
      i_wr_data  = (wq.size() > 0) ? wq[0] : 8'($urandom);
      #1;
      if (o_wr_ready) begin wr_taken = 1; wr_pulses++; end
      if (o_rd_valid) rd_log.push_back(o_rd_data);
      if (o_done) begin done_count++; done_cyc = cyc; done_err = o_err; busy_at_done = o_busy; end
      if (o_cmd_trig) begin
        cmd_log.push_back({o_cmd, o_data});
        pending = 1; pend_cmd = o_cmd; pend_data = o_data;
        last_trig_cyc = cyc; wait_left = $urandom_range(1, 4);
      end else if (pending) begin
        if (o_cmd !== pend_cmd || o_data !== pend_data) unstable++;
        if (cmd_log.size() - 1 == al_at) begin
          i_i2c_al = 1; i_cmd_ack = 1'($urandom_range(0, 1)); al_cyc = cyc; pending = 0;
        end else if (cmd_log.size() - 1 != noack_at) begin
          wait_left--;
          if (wait_left == 0) begin
            i_cmd_ack = 1; pending = 0;
            i_i2c_ack = (pend_cmd == C_RD_ACK) && (rdack_seen == nack_at);
            if (pend_cmd == C_RD_ACK) rdack_seen++;
            if (pend_cmd == C_READ) i_data = (rq.size() > 0) ? rq.pop_front() : 8'hEE;
          end
        end
      end
    end
  end

  // Transaction-level model: full command list, then truncated by the injected fault.
  task automatic model_xfer(input bit rnw, input logic [6:0] dev, input logic [7:0] ra, input int n);
    logic [11:0] full[$];
    int tag[$];
    int r = 0, rd_i = 0;
    full.push_back({C_START, 8'hFF});  tag.push_back(0);
    full.push_back({C_WRITE, dev, 1'b0}); tag.push_back(0);
    full.push_back({C_RD_ACK, 8'hFF}); tag.push_back(0);
    full.push_back({C_WRITE, ra});     tag.push_back(0);
    full.push_back({C_RD_ACK, 8'hFF}); tag.push_back(0);
    if (!rnw) begin
      for (int i = 0; i < n; i++) begin
        full.push_back({C_WRITE, wbytes[i]}); tag.push_back(1);
        full.push_back({C_RD_ACK, 8'hFF});    tag.push_back(0);
      end
    end else begin
      full.push_back({C_RESTART, 8'hFF});   tag.push_back(0);
      full.push_back({C_WRITE, dev, 1'b1}); tag.push_back(0);
      full.push_back({C_RD_ACK, 8'hFF});    tag.push_back(0);
      for (int i = 0; i < n; i++) begin
        full.push_back({C_READ, 8'hFF}); tag.push_back(2);
        full.push_back({(i == n - 1) ? C_WR_NAK : C_WR_ACK, 8'hFF}); tag.push_back(0);
      end
    end
    full.push_back({C_STOP, 8'hFF}); tag.push_back(0);
    exp_cmd = {}; exp_rd = {}; exp_wr = 0; exp_err = 2'd0;
    for (int k = 0; k < full.size(); k++) begin
      exp_cmd.push_back(full[k]);
      if (tag[k] == 1) exp_wr++;
      if (k == al_at) begin exp_err = 2'd2; break; end
      if (k == noack_at) begin exp_err = 2'd3; break; end
      if (tag[k] == 2) begin exp_rd.push_back(rbytes[rd_i]); rd_i++; end
      if (full[k][11:8] == C_RD_ACK) begin
        if (r == nack_at) begin exp_err = 2'd1; exp_cmd.push_back({C_STOP, 8'hFF}); break; end
        r++;
      end
    end
  endtask

  // Issues one request and waits (bounded) for its o_done pulse.
  task automatic start_xfer(input bit rnw, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [3:0] len, input int nk, input int al, input int na,
                            input bit rand_bytes);
    int n = (len == 0) ? 1 : int'(len);
    nack_at = nk; al_at = al; noack_at = na;
    if (rand_bytes) begin
      wbytes = {}; rbytes = {};
      for (int i = 0; i < n; i++) begin
        wbytes.push_back(8'($urandom)); rbytes.push_back(8'($urandom));
      end
    end
    model_xfer(rnw, dev, ra, n);
    wq = {}; rq = {};
    if (rnw) rq = rbytes; else wq = wbytes;
    cmd_log = {}; rd_log = {}; wr_pulses = 0; done_count = 0; rdack_seen = 0; unstable = 0;
    @(negedge clk);
    i_req = 1; i_rnw = rnw; i_dev_addr = dev; i_reg_addr = ra; i_len = len;
    @(negedge clk);
    req_busy = o_busy;
    i_rnw = ~rnw; i_dev_addr = 7'($urandom); i_reg_addr = 8'($urandom); i_len = 4'($urandom);
    @(negedge clk);
    i_req = 0;
    for (int t = 0; t < 3000 && done_count == 0; t++) @(negedge clk);
  endtask

  task automatic test_reset;
    i_reset = 1; repeat (3) @(negedge clk); i_reset = 0; @(negedge clk);
    nvec++;
    if ({o_busy, o_done, o_err, o_cmd_trig, o_wr_ready, o_rd_valid, o_rd_data, o_cmd, o_data}
        !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 8'hFF}) begin
      nerr++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%0d trig=%b rdy=%b rdv=%b rdd=%h cmd=%0d data=%h required all zero, cmd=0, data=ff",
               o_busy, o_done, o_err, o_cmd_trig, o_wr_ready, o_rd_valid, o_rd_data, o_cmd, o_data);
    end
  endtask

  task automatic test_write;
    wbytes = {8'hA5, 8'h3C};
    start_xfer(0, 7'h50, 8'h10, 4'd2, -1, -1, -1, 0);
    nvec++; if (cmd_log.size() != exp_cmd.size()) begin nerr++; $display("FAIL write_cmd_count: got %0d required %0d", cmd_log.size(), exp_cmd.size()); end
    for (int k = 0; k < cmd_log.size() && k < exp_cmd.size(); k++) begin
      nvec++;
      if (cmd_log[k][11:8] !== exp_cmd[k][11:8] || (exp_cmd[k][11:8] == C_WRITE && cmd_log[k][7:0] !== exp_cmd[k][7:0])) begin
        nerr++; $display("FAIL write_cmd[%0d]: got %h required %h", k, cmd_log[k], exp_cmd[k]);
      end
    end
    nvec++; if (wr_pulses != 2) begin nerr++; $display("FAIL write_ready_pulses: got %0d required 2", wr_pulses); end
    nvec++; if (done_count != 1 || done_err !== 2'd0) begin nerr++; $display("FAIL write_done: got count=%0d err=%0d required 1/0", done_count, done_err); end
    nvec++; if (req_busy !== 1'b1 || busy_at_done !== 1'b0) begin nerr++; $display("FAIL write_busy: got rise=%b at_done=%b required 1/0", req_busy, busy_at_done); end
    nvec++; if (unstable != 0) begin nerr++; $display("FAIL write_cmd_stable: got %0d changes required 0", unstable); end
  endtask

  task automatic test_read;
    rbytes = {8'h11, 8'h22, 8'h33};
    start_xfer(1, 7'h50, 8'h02, 4'd3, -1, -1, -1, 0);
    nvec++; if (cmd_log.size() != exp_cmd.size()) begin nerr++; $display("FAIL read_cmd_count: got %0d required %0d", cmd_log.size(), exp_cmd.size()); end
    for (int k = 0; k < cmd_log.size() && k < exp_cmd.size(); k++) begin
      nvec++;
      if (cmd_log[k][11:8] !== exp_cmd[k][11:8] || (exp_cmd[k][11:8] == C_WRITE && cmd_log[k][7:0] !== exp_cmd[k][7:0])) begin
        nerr++; $display("FAIL read_cmd[%0d]: got %h required %h", k, cmd_log[k], exp_cmd[k]);
      end
    end
    nvec++; if (rd_log.size() != 3) begin nerr++; $display("FAIL read_valid_count: got %0d required 3", rd_log.size()); end
    for (int k = 0; k < rd_log.size() && k < exp_rd.size(); k++) begin
      nvec++; if (rd_log[k] !== exp_rd[k]) begin nerr++; $display("FAIL read_data[%0d]: got %h required %h", k, rd_log[k], exp_rd[k]); end
    end
    nvec++; if (done_count != 1 || done_err !== 2'd0) begin nerr++; $display("FAIL read_done: got count=%0d err=%0d required 1/0", done_count, done_err); end
  endtask

  task automatic test_nack;
    start_xfer(0, 7'h50, 8'h10, 4'd2, 0, -1, -1, 1);
    nvec++; if (cmd_log.size() != 4 || cmd_log[cmd_log.size()-1][11:8] !== C_STOP) begin
      nerr++; $display("FAIL nack_stop: got %0d cmds ending %h required 4 ending STOP", cmd_log.size(), (cmd_log.size() > 0) ? cmd_log[cmd_log.size()-1] : 12'h0);
    end
    nvec++; if (wr_pulses != 0) begin nerr++; $display("FAIL nack_ready_pulses: got %0d required 0", wr_pulses); end
    nvec++; if (done_count != 1 || done_err !== 2'd1) begin nerr++; $display("FAIL nack_done: got count=%0d err=%0d required 1/1", done_count, done_err); end
  endtask

  task automatic test_arb_lost;
    start_xfer(0, 7'h50, 8'h10, 4'd2, -1, 3, -1, 1);
    nvec++; if (cmd_log.size() != 4) begin nerr++; $display("FAIL al_cmd_count: got %0d required 4 (no STOP)", cmd_log.size()); end
    nvec++; if (done_count != 1 || done_cyc != al_cyc + 1) begin nerr++; $display("FAIL al_done_timing: got done at %0d, al at %0d, count %0d required al+1", done_cyc, al_cyc, done_count); end
    nvec++; if (done_err !== 2'd2 || busy_at_done !== 1'b0) begin nerr++; $display("FAIL al_done: got err=%0d busy=%b required 2/0", done_err, busy_at_done); end
  endtask

  task automatic test_timeout;
    start_xfer(1, 7'h2A, 8'h33, 4'd1, -1, -1, 0, 1);
    nvec++; if (done_count != 1 || done_cyc - last_trig_cyc != TO) begin nerr++; $display("FAIL timeout_latency: got %0d cycles (count %0d) required %0d", done_cyc - last_trig_cyc, done_count, TO); end
    nvec++; if (done_err !== 2'd3) begin nerr++; $display("FAIL timeout_err: got %0d required 3", done_err); end
    nvec++; if (cmd_log.size() != 1) begin nerr++; $display("FAIL timeout_trig_count: got %0d required 1", cmd_log.size()); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 30; it++) begin
      int mode = $urandom_range(0, 7);
      start_xfer(1'($urandom), 7'($urandom), 8'($urandom), 4'($urandom),
                 (mode == 6) ? int'($urandom_range(0, 3)) : -1,
                 (mode == 7) ? int'($urandom_range(1, 14)) : -1, -1, 1);
      nvec++; if (cmd_log.size() != exp_cmd.size()) begin nerr++; $display("FAIL rand%0d_cmd_count: got %0d required %0d", it, cmd_log.size(), exp_cmd.size()); end
      for (int k = 0; k < cmd_log.size() && k < exp_cmd.size(); k++) begin
        nvec++;
        if (cmd_log[k][11:8] !== exp_cmd[k][11:8] || (exp_cmd[k][11:8] == C_WRITE && cmd_log[k][7:0] !== exp_cmd[k][7:0])) begin
          nerr++; $display("FAIL rand%0d_cmd[%0d]: got %h required %h", it, k, cmd_log[k], exp_cmd[k]);
        end
      end
      nvec++; if (wr_pulses != exp_wr) begin nerr++; $display("FAIL rand%0d_ready_pulses: got %0d required %0d", it, wr_pulses, exp_wr); end
      nvec++; if (rd_log != exp_rd) begin nerr++; $display("FAIL rand%0d_read_data: got %0d bytes required %0d", it, rd_log.size(), exp_rd.size()); end
      nvec++; if (done_count != 1 || done_err !== exp_err) begin nerr++; $display("FAIL rand%0d_done: got count=%0d err=%0d required 1/%0d", it, done_count, done_err, exp_err); end
      nvec++; if (unstable != 0 || req_busy !== 1'b1) begin nerr++; $display("FAIL rand%0d_handshake: got unstable=%0d busy=%b required 0/1", it, unstable, req_busy); end
    end
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 2; j++) begin
      start_xfer(0, 7'h11, 8'h22, 4'd0, -1, -1, -1, 1);
      nvec++; if (cmd_log.size() != 8 || wr_pulses != 1) begin nerr++; $display("FAIL b2b%0d_len0: got %0d cmds %0d pulses required 8/1", j, cmd_log.size(), wr_pulses); end
      nvec++; if (done_count != 1 || done_err !== 2'd0 || req_busy !== 1'b1) begin nerr++; $display("FAIL b2b%0d_done: got count=%0d err=%0d busy=%b required 1/0/1", j, done_count, done_err, req_busy); end
    end
  endtask

  task automatic test_reset_mid;
    int stops = 0;
    nack_at = -1; al_at = -1; noack_at = -1;
    rbytes = {8'h01, 8'h02, 8'h03, 8'h04}; rq = rbytes; wq = {};
    cmd_log = {}; done_count = 0; rdack_seen = 0;
    @(negedge clk); i_req = 1; i_rnw = 1; i_dev_addr = 7'h3C; i_reg_addr = 8'h40; i_len = 4'd4;
    @(negedge clk); i_req = 0;
    repeat (12) @(negedge clk);
    nvec++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL midreset_busy_before: got %b required 1", o_busy); end
    i_reset = 1; @(negedge clk);
    pending = 0; rq = {}; wq = {};
    nvec++;
    if ({o_busy, o_done, o_err, o_cmd_trig, o_wr_ready, o_rd_valid, o_rd_data, o_cmd, o_data}
        !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, C_IDLE, 8'hFF}) begin
      nerr++;
      $display("FAIL midreset_outputs: got busy=%b done=%b err=%0d trig=%b rdy=%b rdv=%b rdd=%h cmd=%0d data=%h required all zero, cmd=0, data=ff",
               o_busy, o_done, o_err, o_cmd_trig, o_wr_ready, o_rd_valid, o_rd_data, o_cmd, o_data);
    end
    i_reset = 0; repeat (3) @(negedge clk);
    foreach (cmd_log[k]) if (cmd_log[k][11:8] == C_STOP) stops++;
    nvec++; if (stops != 0 || done_count != 0) begin nerr++; $display("FAIL midreset_no_stop: got stops=%0d dones=%0d required 0/0", stops, done_count); end
    start_xfer(0, 7'h50, 8'h10, 4'd3, -1, -1, -1, 1);
    nvec++; if (cmd_log.size() != exp_cmd.size() || wr_pulses != 3) begin nerr++; $display("FAIL midreset_next_xfer: got %0d cmds %0d pulses required %0d/3", cmd_log.size(), wr_pulses, exp_cmd.size()); end
    nvec++; if (done_count != 1 || done_err !== 2'd0) begin nerr++; $display("FAIL midreset_next_done: got count=%0d err=%0d required 1/0", done_count, done_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_arb_lost();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
